// File: rtl/key_conditioner.sv
// Synchronises, debounces and edge-detects active-low pushbuttons for the game FSM.
// Optional long-press detection is built only when KEY_LONG_PRESS_EN is defined.
module key_conditioner #(
    parameter int unsigned NUM_KEYS        = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned LONG_CYCLES     = 50000000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] key_raw,
    output logic [NUM_KEYS-1:0] key_clean,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_long
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NUM_KEYS-1:0] sync1_q, sync2_q;
    logic [NUM_KEYS-1:0] level_q, level_d;
    logic [NUM_KEYS-1:0] clean_q, press_q, release_q;
    logic [CNT_W-1:0]    cnt_q [NUM_KEYS];
    logic [CNT_W-1:0]    cnt_d [NUM_KEYS];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= key_raw;
            sync2_q <= sync1_q;
        end
    end

    always_comb begin
        level_d = level_q;
        for (int unsigned i = 0; i < NUM_KEYS; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != level_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    level_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            level_q <= '1;
            for (int unsigned i = 0; i < NUM_KEYS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            level_q <= level_d;
            for (int unsigned i = 0; i < NUM_KEYS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Output stage: the level and its edge pulses leave together one edge after acceptance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clean_q   <= '1;
            press_q   <= '0;
            release_q <= '0;
        end else begin
            clean_q   <= level_q;
            press_q   <= clean_q & ~level_q;
            release_q <= ~clean_q & level_q;
        end
    end

    assign key_clean   = clean_q;
    assign key_press   = press_q;
    assign key_release = release_q;

`ifdef KEY_LONG_PRESS_EN
    localparam int unsigned LONG_W = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;
    localparam logic [LONG_W-1:0] LONG_MAX = LONG_W'(LONG_CYCLES - 1);

    logic [LONG_W-1:0]   hold_q [NUM_KEYS];
    logic [LONG_W-1:0]   hold_d [NUM_KEYS];
    logic [NUM_KEYS-1:0] done_q, done_d;
    logic [NUM_KEYS-1:0] long_q, long_d;

    // done_q saturates the hold count so each press yields at most one pulse.
    always_comb begin
        done_d = done_q;
        long_d = '0;
        for (int unsigned i = 0; i < NUM_KEYS; i++) begin
            hold_d[i] = hold_q[i];
            if (clean_q[i]) begin
                hold_d[i] = '0;
                done_d[i] = 1'b0;
            end else if (!done_q[i]) begin
                if (hold_q[i] == LONG_MAX) begin
                    long_d[i] = 1'b1;
                    done_d[i] = 1'b1;
                end else begin
                    hold_d[i] = hold_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done_q <= '0;
            long_q <= '0;
            for (int unsigned i = 0; i < NUM_KEYS; i++) begin
                hold_q[i] <= '0;
            end
        end else begin
            done_q <= done_d;
            long_q <= long_d;
            for (int unsigned i = 0; i < NUM_KEYS; i++) begin
                hold_q[i] <= hold_d[i];
            end
        end
    end

    assign key_long = long_q;
`else
    assign key_long = '0;
`endif

endmodule
